// File: rtl/alu8_pkg.sv
// Shared ALU8 definitions: command/flag bit positions, op-codes and the host sequencer states.
package alu8_pkg;

  localparam int unsigned CmdMul   = 7;
  localparam int unsigned CmdBcd   = 6;
  localparam int unsigned CmdShr   = 5;
  localparam int unsigned CmdCi    = 4;
  localparam int unsigned CmdOpMsb = 3;
  localparam int unsigned CmdOpLsb = 0;

  localparam logic [3:0] OpAdd   = 4'b0011;
  localparam logic [3:0] OpSub   = 4'b0111;
  localparam logic [3:0] OpAnd   = 4'b1011;
  localparam logic [3:0] OpOr    = 4'b1100;
  localparam logic [3:0] OpXor   = 4'b1101;
  localparam logic [3:0] OpPassB = 4'b1110;
  localparam logic [3:0] OpPassA = 4'b1111;

  localparam int unsigned FlagCo = 4;
  localparam int unsigned FlagV  = 3;
  localparam int unsigned FlagZ  = 2;
  localparam int unsigned FlagN  = 1;
  localparam int unsigned FlagHc = 0;

  typedef enum logic [3:0] {
    StIdle,
    StLdA,
    StLdB,
    StLdC,
    StSelRes,
    StSelFlg,
    StSelMl,
    StSelMh,
    StCap,
    StDone
  } state_e;

endpackage

// File: rtl/alu8_host_seq.sv
// Host-side sequencer for the ALU8 pin protocol (load A/B/cmd, then read result, flags, product).
// Multiply readback is compiled in only when ALU8_HOST_MULT_EN is defined.
module alu8_host_seq
  import alu8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic [7:0]  req_cmd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic [7:0]  rsp_flags,
  output logic [15:0] rsp_mul,
  output logic [7:0]  ABCmd_o,
  output logic        LoadA_o,
  output logic        LoadB_o,
  output logic        LoadCmd_o,
  output logic        MulL_o,
  output logic        MulH_o,
  output logic        Flag_o,
  input  logic [7:0]  ACC_i
);

  state_e     state_q, state_d;
  logic [7:0] a_q, b_q, cmd_q;
  logic [7:0] result_q, flags_q;
  logic       accept;
  logic       mul_l, mul_h;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StLdA;
      StLdA:    state_d = StLdB;
      StLdB:    state_d = StLdC;
      StLdC:    state_d = StSelRes;
      StSelRes: state_d = StSelFlg;
`ifdef ALU8_HOST_MULT_EN
      StSelFlg: state_d = cmd_q[CmdMul] ? StSelMl : StCap;
      StSelMl:  state_d = StSelMh;
      StSelMh:  state_d = StCap;
`else
      StSelFlg: state_d = StCap;
`endif
      StCap:    state_d = StDone;
      StDone:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Pin drive depends on state_q only, so request inputs can never glitch a strobe.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ABCmd_o   = 8'h00;
    LoadA_o   = 1'b0;
    LoadB_o   = 1'b0;
    LoadCmd_o = 1'b0;
    Flag_o    = 1'b0;
    mul_l     = 1'b0;
    mul_h     = 1'b0;
    unique case (state_q)
      StIdle:   req_ready = 1'b1;
      StLdA: begin
        ABCmd_o = a_q;
        LoadA_o = 1'b1;
      end
      StLdB: begin
        ABCmd_o = b_q;
        LoadB_o = 1'b1;
      end
      StLdC: begin
        ABCmd_o   = cmd_q;
        LoadCmd_o = 1'b1;
      end
      StSelFlg: Flag_o = 1'b1;
`ifdef ALU8_HOST_MULT_EN
      StSelMl:  mul_l = 1'b1;
      StSelMh:  mul_h = 1'b1;
`endif
      StDone:   rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign MulL_o = mul_l;
  assign MulH_o = mul_h;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cmd_q    <= 8'h00;
      result_q <= 8'h00;
      flags_q  <= 8'h00;
    end else begin
      if (accept) begin
        a_q   <= req_a;
        b_q   <= req_b;
        cmd_q <= req_cmd;
      end
      // ACC_i reflects the select driven one cycle earlier.
      unique case (state_q)
        StSelFlg: result_q <= ACC_i;
`ifdef ALU8_HOST_MULT_EN
        StSelMl:  flags_q <= ACC_i;
        StCap:    if (!cmd_q[CmdMul]) flags_q <= ACC_i;
`else
        StCap:    flags_q <= ACC_i;
`endif
        default:  ;
      endcase
    end
  end

`ifdef ALU8_HOST_MULT_EN
  logic [15:0] mul_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_q <= 16'h0000;
    end else if (accept) begin
      if (!req_cmd[CmdMul]) mul_q <= 16'h0000;
    end else if (state_q == StSelMh) begin
      mul_q[7:0] <= ACC_i;
    end else if (state_q == StCap && cmd_q[CmdMul]) begin
      mul_q[15:8] <= ACC_i;
    end
  end

  assign rsp_mul = mul_q;
`else
  assign rsp_mul = 16'h0000;
`endif

  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu8_host_seq.sv
// Bench for alu8_host_seq: behavioural ALU8 register model plus a response scoreboard.
module tb_alu8_host_seq;
  import alu8_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [7:0]  req_a, req_b, req_cmd;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_result, rsp_flags;
  logic [15:0] rsp_mul;
  logic [7:0]  abcmd, acc;
  logic        load_a, load_b, load_cmd, mul_l, mul_h, flag;

  always #5 clk = ~clk;

  alu8_host_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cmd    (req_cmd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_mul    (rsp_mul),
    .ABCmd_o    (abcmd),
    .LoadA_o    (load_a),
    .LoadB_o    (load_b),
    .LoadCmd_o  (load_cmd),
    .MulL_o     (mul_l),
    .MulH_o     (mul_h),
    .Flag_o     (flag),
    .ACC_i      (acc)
  );

  // Returns {flags, result} of the ALU8 for one operation.
  function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] cmd);
    logic [8:0] s;
    logic [4:0] h;
    logic [7:0] r;
    logic       co, v, hc, ci;
    co = 1'b0; v = 1'b0; hc = 1'b0; s = 9'd0; h = 5'd0;
    ci = cmd[CmdCi];
    case (cmd[3:0])
      OpAdd: begin
        s  = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        h  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, ci};
        r  = s[7:0];
        co = s[8]; hc = h[4];
        v  = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OpSub: begin
        s  = {1'b0, a} + {1'b0, ~b} + 9'd1;
        h  = {1'b0, a[3:0]} + {1'b0, ~b[3:0]} + 5'd1;
        r  = s[7:0];
        co = s[8]; hc = h[4];
        v  = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpPassB: r = b;
      default: r = a;
    endcase
    return {3'b000, co, v, (r == 8'h00), r[7], hc, r};
  endfunction

  // Behavioural ALU8: operand/command registers and a registered output select.
  logic [7:0]  alu_a, alu_b, alu_cmd;
  logic [15:0] alu_ref, prod;
  assign alu_ref = ref_alu(alu_a, alu_b, alu_cmd);
  assign prod    = 16'(alu_a) * 16'(alu_b);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a <= 8'h00; alu_b <= 8'h00; alu_cmd <= 8'h00; acc <= 8'h00;
    end else begin
      if (load_a)   alu_a   <= abcmd;
      if (load_b)   alu_b   <= abcmd;
      if (load_cmd) alu_cmd <= abcmd;
      if (flag)       acc <= alu_ref[15:8];
      else if (mul_l) acc <= prod[7:0];
      else if (mul_h) acc <= prod[15:8];
      else            acc <= alu_ref[7:0];
    end
  end

  typedef struct {
    logic [7:0]  result;
    logic [7:0]  flags;
    logic [15:0] mul;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cnt = 0;

  logic [5:0] strobes;
  assign strobes = {load_a, load_b, load_cmd, flag, mul_l, mul_h};

  logic [5:0] seq_add [7] = '{6'b100000, 6'b010000, 6'b001000, 6'b000000,
                              6'b000100, 6'b000000, 6'b000000};
`ifdef ALU8_HOST_MULT_EN
  logic [5:0] seq_mul [9] = '{6'b100000, 6'b010000, 6'b001000, 6'b000000, 6'b000100,
                              6'b000010, 6'b000001, 6'b000000, 6'b000000};
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset && req_valid && req_ready) acc_cnt++;
  end

  // Response monitor: pops on the first DONE cycle, then requires fields stable while stalled.
  initial begin : monitor
    logic        valid_d;
    logic [31:0] hold;
    exp_t        e;
    valid_d = 1'b0;
    hold    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        valid_d = 1'b0;
      end else begin
        check("strobe_excl", 32'($countones(strobes) <= 1), 32'd1);
        if (!(load_a || load_b || load_cmd)) check("bus_idle", 32'(abcmd), 32'd0);
        if (rsp_valid && !valid_d) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_result", 32'(rsp_result), 32'(e.result));
            check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
            check("rsp_mul", 32'(rsp_mul), 32'(e.mul));
            check("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
          end
          hold = {rsp_result, rsp_flags, rsp_mul};
        end else if (rsp_valid) begin
          check("rsp_stable", {rsp_result, rsp_flags, rsp_mul}, hold);
        end
        valid_d = rsp_valid;
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accept edge (sequencer in LDA).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] cmd,
                      output int acc_at);
    exp_t        e;
    logic [15:0] r;
    int          n;
    req_valid = 1'b1; req_a = a; req_b = b; req_cmd = cmd;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 40), 32'd1);
    acc_at = cyc + 1;
    r = ref_alu(a, b, cmd);
    e.result  = r[7:0];
    e.flags   = r[15:8];
    e.acc_cyc = acc_at;
`ifdef ALU8_HOST_MULT_EN
    e.mul = cmd[CmdMul] ? 16'(a) * 16'(b) : 16'h0000;
    e.lat = cmd[CmdMul] ? 9 : 7;
`else
    e.mul = 16'h0000;
    e.lat = 7;
`endif
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid || !req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_strobes"}, 32'(strobes), 32'd0);
    check({tag, "_bus"}, 32'(abcmd), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int t, rel, cnt0, n;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_a = 8'h00; req_b = 8'h00; req_cmd = 8'h00;
    repeat (2) @(negedge clk);
    check_idle_outputs("por");
    check("por_fields", {rsp_result, rsp_flags, rsp_mul}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Abort mid-sequence: no partial response may follow.
    send(8'h12, 8'h34, 8'h03, t);
    @(negedge clk);
    check("ldb_strobe", 32'(load_b), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    sb.delete();
    reset = 1'b0;
    @(negedge clk);

    send(8'h12, 8'h34, 8'h03, t);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("add_seq%0d", i), 32'(strobes), 32'(seq_add[i]));
      @(negedge clk);
    end
    wait_drain();

    send(8'h0F, 8'h11, 8'h8F, t);
`ifdef ALU8_HOST_MULT_EN
    for (int i = 0; i < 9; i++) begin
      check($sformatf("mul_seq%0d", i), 32'(strobes), 32'(seq_mul[i]));
      @(negedge clk);
    end
`else
    for (int i = 0; i < 7; i++) begin
      check($sformatf("mul_seq%0d", i), 32'(strobes), 32'(seq_add[i]));
      @(negedge clk);
    end
`endif
    wait_drain();
    send(8'hFF, 8'hFF, 8'h8F, t);
    wait_drain();

    // Backpressure: stall in DONE while the request side wiggles.
    rsp_ready = 1'b0;
    send(8'h55, 8'h23, 8'h07, t);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach_done", 32'(rsp_valid), 32'd1);
    cnt0 = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      req_a = 8'($urandom); req_b = 8'($urandom); req_cmd = 8'($urandom);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    @(negedge clk);
    check("stall_no_accept", 32'(acc_cnt), 32'(cnt0));
    rel = cyc;
    rsp_ready = 1'b1;
    send(8'hA0, 8'h0B, 8'h03, t);
    check("accept_after_release", 32'(t - rel), 32'd2);
    wait_drain();

    for (int i = 0; i < 1000; i++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom), t);
    end
    wait_drain();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
